// File: rtl/noc_pkg.sv
// Shared flit layout helpers and traffic-generator LFSR constants for the mesh NIC.
// Flits are {dst, src, payload}, with dst in the most significant bits.
package noc_pkg;

   localparam int MAX_FLIT_W = 64;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic int dst_lsb(input int flit_w, input int id_w);
      return flit_w - id_w;
   endfunction

   function automatic int src_lsb(input int flit_w, input int id_w);
      return flit_w - 2 * id_w;
   endfunction

   function automatic int payload_w(input int flit_w, input int id_w);
      return flit_w - 2 * id_w;
   endfunction

   function automatic logic [MAX_FLIT_W-1:0] field_mask(input int w);
      return (MAX_FLIT_W'(1) << w) - MAX_FLIT_W'(1);
   endfunction

   function automatic logic [MAX_FLIT_W-1:0] get_dst(input logic [MAX_FLIT_W-1:0] flit,
                                                     input int flit_w, input int id_w);
      return (flit >> dst_lsb(flit_w, id_w)) & field_mask(id_w);
   endfunction

   function automatic logic [MAX_FLIT_W-1:0] get_src(input logic [MAX_FLIT_W-1:0] flit,
                                                     input int flit_w, input int id_w);
      return (flit >> src_lsb(flit_w, id_w)) & field_mask(id_w);
   endfunction

   function automatic logic [MAX_FLIT_W-1:0] get_payload(input logic [MAX_FLIT_W-1:0] flit,
                                                         input int flit_w, input int id_w);
      return flit & field_mask(payload_w(flit_w, id_w));
   endfunction

endpackage

// File: rtl/nic_txq.sv
// TX queue for the NIC: synchronous FIFO with a registered read port.
// dout updates only on a pop and holds its value otherwise, so it drives dataout directly.
module nic_txq #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [PTR_W:0]   count_reg, count_next;
   logic [WIDTH-1:0] dout_reg;
   logic             do_push, do_pop;

   assign full    = (count_reg == FULL_CNT);
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = dout_reg;

   always_comb begin
      count_next = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + (PTR_W+1)'(1);
         2'b01:   count_next = count_reg - (PTR_W+1)'(1);
         default: count_next = count_reg;
      endcase
   end

   // Storage is left unreset so it maps onto RAM primitives
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= din;
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         dout_reg   <= '0;
      end else begin
         count_reg <= count_next;
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            dout_reg   <= mem[rd_ptr_reg];
         end
      end
   end

endmodule

// File: rtl/pe_credit_nic.sv
// Credit-flow-controlled network interface for a mesh PE: TX queue, credit counter, RX sink.
// Optional on-chip traffic generator enabled by defining PE_TRAFFIC_GEN_EN.
module pe_credit_nic
   import noc_pkg::*;
#(
   parameter int FLIT_W    = 20,
   parameter int ID_W      = 4,
   parameter int NODE_ID   = 9,
   parameter int CREDITS   = 4,
   parameter int TXQ_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     RST,
`ifdef PE_TRAFFIC_GEN_EN
   input  logic                     gen_en,
`endif
   input  logic                     tx_req,
   input  logic [ID_W-1:0]          tx_dst,
   input  logic [FLIT_W-2*ID_W-1:0] tx_payload,
   output logic                     tx_ready,
   output logic [FLIT_W-1:0]        dataout,
   output logic                     out_valid,
   input  logic                     ci,
   input  logic [FLIT_W-1:0]        datain,
   input  logic                     in_valid,
   output logic                     co,
   output logic [FLIT_W-2*ID_W-1:0] rx_payload,
   output logic [ID_W-1:0]          rx_src,
   output logic                     rx_valid,
   output logic [15:0]              rx_count,
   output logic                     misroute,
   output logic                     credit_err
);

   localparam int PAY_W = FLIT_W - 2 * ID_W;
   localparam int CNT_W = $clog2(CREDITS + 1);
   localparam logic [CNT_W-1:0] CREDITS_MAX = CNT_W'(CREDITS);
   localparam logic [ID_W-1:0]  NODE        = ID_W'(NODE_ID);

   logic              txq_full, txq_empty;
   logic              push, send;
   logic [ID_W-1:0]   push_dst;
   logic [PAY_W-1:0]  push_payload;
   logic [FLIT_W-1:0] push_flit;

   logic [CNT_W-1:0]  credits_reg, credits_next;
   logic              credit_err_reg, credit_err_next;
   logic              out_valid_reg;

   logic              co_reg, rx_valid_reg, misroute_reg;
   logic [PAY_W-1:0]  rx_payload_reg;
   logic [ID_W-1:0]   rx_src_reg;
   logic [15:0]       rx_count_reg;
   logic [ID_W-1:0]   rx_dst_w, rx_src_w;
   logic [PAY_W-1:0]  rx_payload_w;

`ifdef PE_TRAFFIC_GEN_EN
   logic [15:0]     lfsr_reg, lfsr_next, seq_reg;
   logic            gen_push;
   logic [ID_W-1:0] gen_dst;

   assign gen_push  = gen_en && !txq_full;
   assign lfsr_next = {lfsr_reg[14:0], ^(lfsr_reg & LFSR_TAPS)};
   // Never address ourselves: bump a self-hit to the next node ID
   assign gen_dst   = (lfsr_reg[ID_W-1:0] == NODE) ? NODE + ID_W'(1) : lfsr_reg[ID_W-1:0];

   assign push         = gen_en ? gen_push : (tx_req && !txq_full);
   assign push_dst     = gen_en ? gen_dst : tx_dst;
   assign push_payload = gen_en ? PAY_W'(seq_reg) : tx_payload;
   assign tx_ready     = !txq_full && !gen_en;

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         lfsr_reg <= LFSR_SEED;
         seq_reg  <= '0;
      end else if (gen_push) begin
         lfsr_reg <= lfsr_next;
         seq_reg  <= seq_reg + 16'd1;
      end
   end
`else
   assign push         = tx_req && !txq_full;
   assign push_dst     = tx_dst;
   assign push_payload = tx_payload;
   assign tx_ready     = !txq_full;
`endif

   assign push_flit = {push_dst, NODE, push_payload};
   assign send      = !txq_empty && (credits_reg != '0);

   nic_txq #(
      .WIDTH (FLIT_W),
      .DEPTH (TXQ_DEPTH)
   ) u_txq (
      .clk   (clk),
      .RST   (RST),
      .push  (push),
      .pop   (send),
      .din   (push_flit),
      .dout  (dataout),
      .full  (txq_full),
      .empty (txq_empty)
   );

   always_comb begin
      credits_next    = credits_reg;
      credit_err_next = credit_err_reg;
      if (send && !ci) begin
         credits_next = credits_reg - CNT_W'(1);
      end else if (ci && !send) begin
         // A return with nothing outstanding is an upstream protocol error
         if (credits_reg == CREDITS_MAX) credit_err_next = 1'b1;
         else                            credits_next    = credits_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         credits_reg    <= CREDITS_MAX;
         credit_err_reg <= 1'b0;
         out_valid_reg  <= 1'b0;
      end else begin
         credits_reg    <= credits_next;
         credit_err_reg <= credit_err_next;
         out_valid_reg  <= send;
      end
   end

   assign rx_dst_w     = ID_W'(get_dst(MAX_FLIT_W'(datain), FLIT_W, ID_W));
   assign rx_src_w     = ID_W'(get_src(MAX_FLIT_W'(datain), FLIT_W, ID_W));
   assign rx_payload_w = PAY_W'(get_payload(MAX_FLIT_W'(datain), FLIT_W, ID_W));

   // Always-ready sink: every valid flit is counted and its slot credited back
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         co_reg         <= 1'b0;
         rx_valid_reg   <= 1'b0;
         rx_payload_reg <= '0;
         rx_src_reg     <= '0;
         rx_count_reg   <= '0;
         misroute_reg   <= 1'b0;
      end else begin
         co_reg       <= in_valid;
         rx_valid_reg <= in_valid;
         if (in_valid) begin
            rx_payload_reg <= rx_payload_w;
            rx_src_reg     <= rx_src_w;
            rx_count_reg   <= rx_count_reg + 16'd1;
            if (rx_dst_w != NODE) misroute_reg <= 1'b1;
         end
      end
   end

   assign out_valid  = out_valid_reg;
   assign credit_err = credit_err_reg;
   assign co         = co_reg;
   assign rx_valid   = rx_valid_reg;
   assign rx_payload = rx_payload_reg;
   assign rx_src     = rx_src_reg;
   assign rx_count   = rx_count_reg;
   assign misroute   = misroute_reg;

endmodule

// File: tb/tb_pe_credit_nic.sv
// Directed self-checking bench for pe_credit_nic with default parameters (node 9, 4 credits, 4-deep queue).
module tb_pe_credit_nic;

   logic        clk = 1'b0;
   logic        RST;
   logic        tx_req;
   logic [3:0]  tx_dst;
   logic [11:0] tx_payload;
   logic        tx_ready;
   logic [19:0] dataout;
   logic        out_valid;
   logic        ci;
   logic [19:0] datain;
   logic        in_valid;
   logic        co;
   logic [11:0] rx_payload;
   logic [3:0]  rx_src;
   logic        rx_valid;
   logic [15:0] rx_count;
   logic        misroute;
   logic        credit_err;

   int checks = 0;
   int errors = 0;

   pe_credit_nic dut (
      .clk        (clk),
      .RST        (RST),
`ifdef PE_TRAFFIC_GEN_EN
      .gen_en     (1'b0),
`endif
      .tx_req     (tx_req),
      .tx_dst     (tx_dst),
      .tx_payload (tx_payload),
      .tx_ready   (tx_ready),
      .dataout    (dataout),
      .out_valid  (out_valid),
      .ci         (ci),
      .datain     (datain),
      .in_valid   (in_valid),
      .co         (co),
      .rx_payload (rx_payload),
      .rx_src     (rx_src),
      .rx_valid   (rx_valid),
      .rx_count   (rx_count),
      .misroute   (misroute),
      .credit_err (credit_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [19:0] mk(input logic [3:0] d, input logic [3:0] s, input logic [11:0] p);
      return {d, s, p};
   endfunction

   task automatic test_reset();
      RST = 1'b0; tx_req = 0; tx_dst = 0; tx_payload = 0; ci = 0; datain = 0; in_valid = 0;
      repeat (3) step();
      RST = 1'b1;
      step();
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (rx_count !== 16'd0) begin errors++; $display("FAIL reset_rx_count got=%h exp=0", rx_count); end
      checks++; if (dut.credits_reg !== 3'd4) begin errors++; $display("FAIL reset_credits got=%0d exp=4", dut.credits_reg); end
      checks++; if ({dataout, co, rx_valid, misroute, credit_err} !== 24'd0) begin
         errors++; $display("FAIL reset_outputs got=%h co=%b rxv=%b mis=%b cerr=%b exp all 0",
                            dataout, co, rx_valid, misroute, credit_err);
      end
      $display("reset: tx_ready=%b credits=%0d", tx_ready, dut.credits_reg);
   endtask

   task automatic test_credit_exhaustion();
      int n = 0;
      logic [19:0] exp_f;
      for (int i = 0; i < 12; i++) begin
         if (i < 6) begin tx_req = 1; tx_dst = 4'h3; tx_payload = 12'(i + 1); end
         else tx_req = 0;
         step();
         if (out_valid) begin
            exp_f = mk(4'h3, 4'h9, 12'(n + 1));
            checks++;
            if (dataout !== exp_f) begin errors++; $display("FAIL exhaust_flit%0d got=%h exp=%h", n, dataout, exp_f); end
            $display("exhaust: flit %0d dataout=%h", n, dataout);
            n++;
         end
      end
      checks++; if (n !== 4) begin errors++; $display("FAIL exhaust_pulses got=%0d exp=4", n); end
      ci = 1; step(); ci = 0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL exhaust_ci_early got=%b exp=0", out_valid); end
      step();
      checks++; if (out_valid !== 1'b1 || dataout !== mk(4'h3, 4'h9, 12'h005)) begin
         errors++; $display("FAIL exhaust_after_ci got v=%b d=%h exp v=1 d=39005", out_valid, dataout);
      end
      $display("exhaust: after ci v=%b dataout=%h", out_valid, dataout);
      ci = 1; step(); ci = 0;
      repeat (3) step();
   endtask

   task automatic test_send_and_ci();
      ci = 1; step(); step(); ci = 0;
      checks++; if (dut.credits_reg !== 3'd2) begin errors++; $display("FAIL sci_setup_credits got=%0d exp=2", dut.credits_reg); end
      tx_req = 1; tx_dst = 4'h1; tx_payload = 12'h0AA; step();
      tx_req = 0; ci = 1; step(); ci = 0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sci_send got=%b exp=1", out_valid); end
      checks++; if (dut.credits_reg !== 3'd2) begin errors++; $display("FAIL sci_credits got=%0d exp=2", dut.credits_reg); end
      checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL sci_credit_err got=%b exp=0", credit_err); end
      $display("send+ci: credits=%0d credit_err=%b", dut.credits_reg, credit_err);
   endtask

   task automatic test_queue_full();
      int n = 0;
      logic [19:0] exp_f;
      tx_req = 1; tx_dst = 4'h3; tx_payload = 12'h0F1; step();
      tx_payload = 12'h0F2; step();
      tx_req = 0; repeat (3) step();
      checks++; if (dut.credits_reg !== 3'd0) begin errors++; $display("FAIL qf_setup_credits got=%0d exp=0", dut.credits_reg); end
      for (int i = 0; i < 4; i++) begin
         tx_req = 1; tx_dst = 4'h6; tx_payload = 12'(12'h101 + i); step();
      end
      checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL qf_tx_ready got=%b exp=0", tx_ready); end
      tx_payload = 12'h105; step(); tx_req = 0;
      for (int i = 0; i < 10; i++) begin
         ci = (i < 4);
         step();
         if (out_valid) begin
            exp_f = mk(4'h6, 4'h9, 12'(12'h101 + n));
            checks++;
            if (dataout !== exp_f) begin errors++; $display("FAIL qf_flit%0d got=%h exp=%h", n, dataout, exp_f); end
            $display("queue full: flit %0d dataout=%h", n, dataout);
            n++;
         end
      end
      ci = 0;
      checks++; if (n !== 4) begin errors++; $display("FAIL qf_pulses got=%0d exp=4", n); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL qf_drained_ready got=%b exp=1", tx_ready); end
   endtask

   task automatic test_rx();
      in_valid = 1; datain = mk(4'h9, 4'h2, 12'hABC); step();
      checks++; if ({co, rx_valid} !== 2'b11 || rx_count !== 16'd1) begin
         errors++; $display("FAIL rx1_strobe got co=%b v=%b cnt=%0d exp 1 1 1", co, rx_valid, rx_count);
      end
      checks++; if (rx_payload !== 12'hABC || rx_src !== 4'h2 || misroute !== 1'b0) begin
         errors++; $display("FAIL rx1_fields got p=%h s=%h mis=%b exp p=abc s=2 mis=0", rx_payload, rx_src, misroute);
      end
      $display("rx: flit 1 cnt=%0d payload=%h src=%h", rx_count, rx_payload, rx_src);
      datain = mk(4'h5, 4'h2, 12'h123); step();
      in_valid = 0;
      checks++; if ({co, rx_valid} !== 2'b11 || rx_count !== 16'd2) begin
         errors++; $display("FAIL rx2_strobe got co=%b v=%b cnt=%0d exp 1 1 2", co, rx_valid, rx_count);
      end
      checks++; if (misroute !== 1'b1 || rx_payload !== 12'h123) begin
         errors++; $display("FAIL rx2_misroute got mis=%b p=%h exp mis=1 p=123", misroute, rx_payload);
      end
      $display("rx: flit 2 cnt=%0d misroute=%b", rx_count, misroute);
      step();
      checks++; if ({co, rx_valid} !== 2'b00 || misroute !== 1'b1 || rx_count !== 16'd2) begin
         errors++; $display("FAIL rx_idle got co=%b v=%b mis=%b cnt=%0d exp 0 0 1 2", co, rx_valid, misroute, rx_count);
      end
   endtask

   task automatic test_credit_overflow();
      ci = 1; repeat (4) step(); ci = 0;
      checks++; if (dut.credits_reg !== 3'd4 || credit_err !== 1'b0) begin
         errors++; $display("FAIL ovf_refill got cr=%0d err=%b exp 4 0", dut.credits_reg, credit_err);
      end
      ci = 1; step(); ci = 0;
      checks++; if (dut.credits_reg !== 3'd4 || credit_err !== 1'b1) begin
         errors++; $display("FAIL ovf_err got cr=%0d err=%b exp 4 1", dut.credits_reg, credit_err);
      end
      $display("overflow: credits=%0d credit_err=%b", dut.credits_reg, credit_err);
      tx_req = 1; tx_dst = 4'h3; tx_payload = 12'h201;
      in_valid = 1; datain = mk(4'h9, 4'h1, 12'h055);
      step(); step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got=%b exp=1", out_valid); end
      #2 RST = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || tx_ready !== 1'b1 || dut.credits_reg !== 3'd4 || rx_count !== 16'd0) begin
         errors++; $display("FAIL async_rst got v=%b rdy=%b cr=%0d cnt=%0d exp 0 1 4 0",
                            out_valid, tx_ready, dut.credits_reg, rx_count);
      end
      checks++; if ({dataout, co, rx_valid, misroute, credit_err} !== 24'd0) begin
         errors++; $display("FAIL async_rst_outs got d=%h co=%b v=%b mis=%b err=%b exp all 0",
                            dataout, co, rx_valid, misroute, credit_err);
      end
      $display("async reset: out_valid=%b credits=%0d rx_count=%0d", out_valid, dut.credits_reg, rx_count);
      tx_req = 0; in_valid = 0;
      @(posedge clk); #1 RST = 1'b1;
      step();
      checks++; if (tx_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL post_rst got rdy=%b v=%b exp 1 0", tx_ready, out_valid);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_credit_exhaustion();
      test_send_and_ci();
      test_queue_full();
      test_rx();
      test_credit_overflow();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pe_credit_nic.md
Name: pe_credit_nic

Overview:
- Parametrised network interface for a mesh processing element.
- Accepts payloads from local logic into a TX queue and formats them as flits with destination and source fields.
- Injects flits into the router port under credit-based flow control.
- Sinks incoming flits, checks their destination, counts them and returns credits upstream.
- Successor to the fixed-ID, fixed-depth PE: node ID, flit width, credit depth and queue depth are parameters.

Parameters:
- FLIT_W, 20, flit width in bits; layout {dst[ID_W], src[ID_W], payload[FLIT_W-2*ID_W]}.
- ID_W, 4, node-ID field width.
- NODE_ID, 9, this node's ID; must be < 2**ID_W.
- CREDITS, 4, downstream buffer slots; initial and maximum credit count.
- TXQ_DEPTH, 4, TX queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- tx_req  in  1  local push request
- tx_dst  in  ID_W  destination of the pushed payload
- tx_payload  in  FLIT_W-2*ID_W  payload
- tx_ready  out  1  queue can accept; push occurs when tx_req && tx_ready
- dataout  out  FLIT_W  flit to router
- out_valid  out  1  dataout valid this cycle
- ci  in  1  credit return from router, one pulse per freed slot
- datain  in  FLIT_W  flit from router
- in_valid  in  1  datain valid
- co  out  1  credit return to router
- rx_payload  out  FLIT_W-2*ID_W  payload of the last accepted flit
- rx_src  out  ID_W  source of the last accepted flit
- rx_valid  out  1  one-cycle pulse per accepted flit
- rx_count  out  16  accepted-flit counter, wraps 0xFFFF->0
- misroute  out  1  sticky: a flit arrived with dst != NODE_ID
- credit_err  out  1  sticky: ci arrived while credits == CREDITS

Behaviour:
- Reset (async assert, sync release) values:
  - credits = CREDITS; queue empty; tx_ready = 1.
  - All other outputs 0, including dataout, out_valid, co, rx_*, rx_count and both flags.
- Push:
  - Queue entry stored as {tx_dst, NODE_ID, tx_payload}.
  - tx_ready = !full, combinational from the occupancy register.
- Send:
  - send = !empty && credits != 0, evaluated on registered state.
  - On send: pop the head; register dataout = head and out_valid = 1 the next cycle.
  - Otherwise out_valid = 0 and dataout holds its last value.
  - Latency: push to out_valid is 2 cycles with credits available and an empty queue.
  - Sustained throughput is 1 flit/cycle.
- Push and pop in the same cycle:
  - Occupancy unchanged.
  - When full, a push is refused (tx_ready = 0) even if a pop occurs that cycle.
- Credit counter (width clog2(CREDITS+1)):
  - send && !ci: decrement.
  - ci && !send: increment.
  - Both: unchanged.
  - ci at CREDITS with no send: hold and set credit_err.
  - Credits never underflow because send requires credits != 0.
- RX:
  - Every in_valid cycle is accepted unconditionally; the NIC is an always-ready sink.
  - Next cycle: co = 1, rx_valid = 1, rx_payload/rx_src latched, rx_count += 1.
  - If dst != NODE_ID: the flit is still counted and credited, and misroute is set.
  - Back-to-back in_valid gives back-to-back co pulses.
- Sticky flags clear only on reset.
- TX and RX paths are independent; all events may occur in the same cycle.

Optional Feature:
- Macro: PE_TRAFFIC_GEN_EN.
- With the macro defined:
  - Adds input gen_en (1 bit) and an internal 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 on reset).
  - While gen_en = 1, each cycle the queue is not full, the block pushes one flit:
    - dst = LFSR[ID_W-1:0]; if that equals NODE_ID, use NODE_ID+1 mod 2**ID_W.
    - payload = low payload bits of a 16-bit sequence counter.
  - The LFSR advances only on a generated push.
  - While gen_en = 1, tx_ready = 0 and tx_req is ignored.
- Without the macro: no gen_en port, no LFSR; the external push path is the only source.

Decomposition:
- Package noc_pkg:
  - flit field widths and offsets, and functions get_dst/get_src/get_payload.
  - LFSR seed and taps constants.
- One sub-module: nic_txq, a synchronous FIFO of width FLIT_W and depth TXQ_DEPTH with full/empty flags.
- Credit counter, RX logic and generator stay in the top module.

Test Plan:
- Reset check:
  - Stimulus: hold RST low, then release; CREDITS=4.
  - Response: tx_ready=1, out_valid=0, rx_count=0, credits=4.
- Credit exhaustion:
  - Stimulus: push 6 payloads (dst=3, payload 0x001..0x006), ci held 0.
  - Response: exactly 4 out_valid pulses with dataout = {4'h3, 4'h9, 12'h001..004}, then stall.
  - Then one ci pulse: flit 0x005 appears 1 cycle later.
- Simultaneous send and ci:
  - Stimulus: ci asserted on the same cycle as a send, credits=2.
  - Response: credits remain 2; credit_err stays 0.
- Queue full:
  - Stimulus: credits=0, push TXQ_DEPTH=4 payloads.
  - Response: tx_ready=0 after the 4th push; a 5th tx_req is dropped.
  - Then ci x4: all 4 flits emerge in order.
- RX path:
  - Stimulus: in_valid with dst=9, src=2, payload=0xABC; then with dst=5.
  - Response: co, rx_valid and rx_count=1 then 2; rx_payload=0xABC, rx_src=2; misroute=1 after the second flit.
- Credit overflow:
  - Stimulus: ci pulse at full credits.
  - Response: credit_err=1, credits stay 4.
  - Then assert RST low mid-transfer: all state returns to reset values immediately.
